// File: rtl/ekf_state_mem_pkg.sv
// Shared types and address-map helpers for the EKF state store.
// Map: x[i] at i, P[r][c] at N+r*N+c, z[k] at N+N*N+k.
package ekf_mem_pkg;

   localparam int unsigned DEF_STATE_DIM = 4;
   localparam int unsigned DEF_MEAS_DIM  = 2;

   function automatic int unsigned x_base(input int unsigned n, input int unsigned m);
      x_base = 0 * (n + m);
   endfunction

   function automatic int unsigned p_base(input int unsigned n, input int unsigned m);
      p_base = n + 0 * m;
   endfunction

   function automatic int unsigned z_base(input int unsigned n, input int unsigned m);
      z_base = n + n * n + 0 * m;
   endfunction

   function automatic int unsigned p_addr(input int unsigned n, input int unsigned r,
                                          input int unsigned c);
      p_addr = n + r * n + c;
   endfunction

   localparam int unsigned X_BASE = x_base(DEF_STATE_DIM, DEF_MEAS_DIM);
   localparam int unsigned P_BASE = p_base(DEF_STATE_DIM, DEF_MEAS_DIM);
   localparam int unsigned Z_BASE = z_base(DEF_STATE_DIM, DEF_MEAS_DIM);

   typedef enum logic [1:0] {IDLE, COPY, SESSION, COMMIT} state_t;
   typedef enum logic [1:0] {REG_X, REG_P, REG_Z, REG_INV} region_t;

endpackage

// File: rtl/ekf_state_mem_if.sv
// Host and compute access bundle for ekf_state_mem.
interface ekf_state_mem_if #(
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  host_wr_en;
   logic                  host_rd_en;
   logic [ADDR_W-1:0]     host_addr;
   logic [DATA_WIDTH-1:0] host_wr_data;
   logic [DATA_WIDTH-1:0] host_rd_data;
   logic                  host_rd_valid;
   logic                  host_wr_drop;
   logic                  cmp_start;
   logic                  cmp_commit;
   logic                  cmp_abort;
   logic                  cmp_req;
   logic                  cmp_we;
   logic [ADDR_W-1:0]     cmp_addr;
   logic [DATA_WIDTH-1:0] cmp_wdata;
   logic                  cmp_gnt;
   logic [DATA_WIDTH-1:0] cmp_rdata;
   logic                  cmp_rvalid;
   logic                  busy;
   logic                  addr_err;

   modport master (
      output host_wr_en, host_rd_en, host_addr, host_wr_data,
      output cmp_start, cmp_commit, cmp_abort, cmp_req, cmp_we, cmp_addr, cmp_wdata,
      input  host_rd_data, host_rd_valid, host_wr_drop,
      input  cmp_gnt, cmp_rdata, cmp_rvalid, busy, addr_err
   );

   modport slave (
      input  host_wr_en, host_rd_en, host_addr, host_wr_data,
      input  cmp_start, cmp_commit, cmp_abort, cmp_req, cmp_we, cmp_addr, cmp_wdata,
      output host_rd_data, host_rd_valid, host_wr_drop,
      output cmp_gnt, cmp_rdata, cmp_rvalid, busy, addr_err
   );
endinterface

// File: rtl/ekf_state_mem_addr_dec.sv
// Combinational address decode: region, range check, P row/col and the
// transposed P address used by the optional symmetric-write mirror.
module ekf_mem_addr_dec
   import ekf_mem_pkg::*;
#(
   parameter int unsigned N      = 4,
   parameter int unsigned M      = 2,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned RC_W   = (N > 1) ? $clog2(N) : 1
) (
   input  logic [ADDR_W-1:0] addr,
   output region_t           region,
   output logic              in_range,
   output logic [RC_W-1:0]   row,
   output logic [RC_W-1:0]   col,
   output logic              offdiag,
   output logic [ADDR_W-1:0] mirror_addr
);
   localparam int unsigned PB  = p_base(N, M);
   localparam int unsigned ZB  = z_base(N, M);
   localparam int unsigned DEP = ZB + M;

   int unsigned a_i;
   int unsigned r_i;
   int unsigned c_i;

   always_comb begin
      a_i         = 32'(addr);
      r_i         = 0;
      c_i         = 0;
      region      = REG_INV;
      in_range    = 1'b0;
      offdiag     = 1'b0;
      mirror_addr = addr;
      if (a_i < PB) begin
         region   = REG_X;
         in_range = 1'b1;
      end else if (a_i < ZB) begin
         region      = REG_P;
         in_range    = 1'b1;
         r_i         = (a_i - PB) / N;
         c_i         = (a_i - PB) % N;
         offdiag     = (r_i != c_i);
         mirror_addr = ADDR_W'(p_addr(N, c_i, r_i));
      end else if (a_i < DEP) begin
         region   = REG_Z;
         in_range = 1'b1;
      end
      row = RC_W'(r_i);
      col = RC_W'(c_i);
   end
endmodule

// File: rtl/ekf_state_mem.sv
// Double-buffered EKF x/P/z store: host sees the active bank, compute works on a
// private copy published on commit. Optional macro EKF_MEM_SYMM_EN mirrors P writes.
module ekf_state_mem
   import ekf_mem_pkg::*;
#(
   parameter int unsigned STATE_DIM  = DEF_STATE_DIM,
   parameter int unsigned MEAS_DIM   = DEF_MEAS_DIM,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = STATE_DIM * STATE_DIM + STATE_DIM + MEAS_DIM,
   parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
   input logic            clk,
   input logic            rst_n,
   ekf_state_mem_if.slave bus
);
   localparam int unsigned RC_W = (STATE_DIM > 1) ? $clog2(STATE_DIM) : 1;
`ifdef EKF_MEM_SYMM_EN
   localparam bit SYMM_EN = 1'b1;
`else
   localparam bit SYMM_EN = 1'b0;
`endif

   state_t                state_q, state_d;
   logic                  act_sel;
   logic [DATA_WIDTH-1:0] bank0 [DEPTH];
   logic [DATA_WIDTH-1:0] bank1 [DEPTH];

   region_t           h_region, c_region;
   logic              h_ok, c_ok, h_offdiag, c_offdiag;
   logic [RC_W-1:0]   h_r, h_c, c_r, c_c;
   logic [ADDR_W-1:0] h_mirror, c_mirror;
   logic              unused_dec;

   ekf_mem_addr_dec #(.N(STATE_DIM), .M(MEAS_DIM), .ADDR_W(ADDR_W), .RC_W(RC_W)) u_host_dec (
      .addr(bus.host_addr), .region(h_region), .in_range(h_ok), .row(h_r), .col(h_c),
      .offdiag(h_offdiag), .mirror_addr(h_mirror));

   ekf_mem_addr_dec #(.N(STATE_DIM), .M(MEAS_DIM), .ADDR_W(ADDR_W), .RC_W(RC_W)) u_cmp_dec (
      .addr(bus.cmp_addr), .region(c_region), .in_range(c_ok), .row(c_r), .col(c_c),
      .offdiag(c_offdiag), .mirror_addr(c_mirror));

   assign unused_dec = ^{h_region, h_r, h_c, h_offdiag, h_mirror, c_region, c_r, c_c};

   logic gnt, host_we, cmp_wr, cmp_mir;
   assign gnt     = bus.cmp_req && (state_q == SESSION);
   assign host_we = bus.host_wr_en && h_ok && (state_q == IDLE);
   assign cmp_wr  = gnt && bus.cmp_we && c_ok;
   assign cmp_mir = cmp_wr && SYMM_EN && c_offdiag;

   assign bus.cmp_gnt = gnt;
   assign bus.busy    = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.cmp_start) state_d = COPY;
         COPY:    state_d = SESSION;
         SESSION: begin
            if (bus.cmp_abort)       state_d = IDLE;
            else if (bus.cmp_commit) state_d = COMMIT;
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         act_sel <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == COMMIT) act_sel <= ~act_sel;
      end
   end

   // Host writes and compute writes never coincide: they are legal in disjoint states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            bank0[i] <= '0;
            bank1[i] <= '0;
         end
      end else begin
         if (state_q == COPY) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               if (act_sel) bank0[i] <= bank1[i];
               else         bank1[i] <= bank0[i];
            end
         end
         if (host_we) begin
            if (act_sel) bank1[bus.host_addr] <= bus.host_wr_data;
            else         bank0[bus.host_addr] <= bus.host_wr_data;
         end
         if (cmp_wr) begin
            if (act_sel) bank0[bus.cmp_addr] <= bus.cmp_wdata;
            else         bank1[bus.cmp_addr] <= bus.cmp_wdata;
         end
         if (cmp_mir) begin
            if (act_sel) bank0[c_mirror] <= bus.cmp_wdata;
            else         bank1[c_mirror] <= bus.cmp_wdata;
         end
      end
   end

   logic [DATA_WIDTH-1:0] host_word, cmp_word;
   always_comb begin
      host_word = '0;
      cmp_word  = '0;
      if (h_ok) host_word = act_sel ? bank1[bus.host_addr] : bank0[bus.host_addr];
      if (c_ok) cmp_word  = act_sel ? bank0[bus.cmp_addr]  : bank1[bus.cmp_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.host_rd_data  <= '0;
         bus.host_rd_valid <= 1'b0;
         bus.host_wr_drop  <= 1'b0;
         bus.cmp_rdata     <= '0;
         bus.cmp_rvalid    <= 1'b0;
         bus.addr_err      <= 1'b0;
      end else begin
         bus.host_rd_valid <= bus.host_rd_en;
         if (bus.host_rd_en) bus.host_rd_data <= host_word;
         bus.host_wr_drop  <= bus.host_wr_en && (state_q != IDLE);
         bus.cmp_rvalid    <= gnt && !bus.cmp_we;
         if (gnt && !bus.cmp_we) bus.cmp_rdata <= cmp_word;
         bus.addr_err      <= ((bus.host_wr_en || bus.host_rd_en) && !h_ok) || (gnt && !c_ok);
      end
   end
endmodule

// File: tb/tb_ekf_state_mem.sv
// Directed bench for ekf_state_mem; expectations for addr 13 follow EKF_MEM_SYMM_EN.
module tb_ekf_state_mem;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   ekf_state_mem_if #(.ADDR_W(5), .DATA_WIDTH(32)) bus ();

   ekf_state_mem #(.STATE_DIM(4), .MEAS_DIM(2), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic host_wr(input logic [4:0] a, input logic [31:0] d);
      bus.host_wr_en = 1'b1; bus.host_addr = a; bus.host_wr_data = d;
      tick();
      bus.host_wr_en = 1'b0;
   endtask

   task automatic host_rd(input logic [4:0] a);
      bus.host_rd_en = 1'b1; bus.host_addr = a;
      tick();
      bus.host_rd_en = 1'b0;
   endtask

   task automatic cmp_acc(input logic we, input logic [4:0] a, input logic [31:0] d);
      bus.cmp_req = 1'b1; bus.cmp_we = we; bus.cmp_addr = a; bus.cmp_wdata = d;
      tick();
      bus.cmp_req = 1'b0; bus.cmp_we = 1'b0;
   endtask

   task automatic open_session();
      bus.cmp_start = 1'b1;
      tick();
      bus.cmp_start = 1'b0;
      tick();
   endtask

   initial begin
      logic [31:0] exp13;
      checks = 0; errors = 0;
      rst_n = 1'b0;
      bus.host_wr_en = 0; bus.host_rd_en = 0; bus.host_addr = '0; bus.host_wr_data = '0;
      bus.cmp_start = 0; bus.cmp_commit = 0; bus.cmp_abort = 0; bus.cmp_req = 0;
      bus.cmp_we = 0; bus.cmp_addr = '0; bus.cmp_wdata = '0;
      tick(); tick();
      chk("rst_rd_valid", 32'(bus.host_rd_valid), 0);
      chk("rst_rd_data", bus.host_rd_data, 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_addr_err", 32'(bus.addr_err), 0);
      chk("rst_cmp_rvalid", 32'(bus.cmp_rvalid), 0);
      rst_n = 1'b1;

      host_wr(5'd5, 32'h3F80_0000);
      chk("idle_wr_no_drop", 32'(bus.host_wr_drop), 0);
      host_rd(5'd5);
      chk("rd5_valid", 32'(bus.host_rd_valid), 1);
      chk("rd5_data", bus.host_rd_data, 32'h3F80_0000);
      host_rd(5'd21);
      chk("rd21_data", bus.host_rd_data, 0);
      tick();
      chk("rd_valid_clears", 32'(bus.host_rd_valid), 0);

      host_wr(5'd0, 32'h1111_1111);
      host_wr(5'd3, 32'h3333_3333);
      host_wr(5'd13, 32'h0000_000D);

      bus.cmp_req = 1'b1; bus.cmp_addr = 5'd0;
      #1;
      chk("idle_no_gnt", 32'(bus.cmp_gnt), 0);
      bus.cmp_req = 1'b0;

      // Session 1: commit path
      bus.cmp_start = 1'b1;
      tick();
      bus.cmp_start = 1'b0;
      chk("copy_busy", 32'(bus.busy), 1);
      bus.cmp_req = 1'b1; bus.cmp_we = 1'b1; bus.cmp_addr = 5'd0; bus.cmp_wdata = 32'h1234_5678;
      #1;
      chk("copy_no_gnt", 32'(bus.cmp_gnt), 0);
      tick();
      chk("session_gnt", 32'(bus.cmp_gnt), 1);
      tick();
      bus.cmp_req = 1'b0; bus.cmp_we = 1'b0;
      cmp_acc(1'b0, 5'd0, '0);
      chk("cmp_rvalid", 32'(bus.cmp_rvalid), 1);
      chk("cmp_rd_after_wr", bus.cmp_rdata, 32'h1234_5678);
      host_rd(5'd0);
      chk("host_sees_old", bus.host_rd_data, 32'h1111_1111);
      host_wr(5'd0, 32'hBAD0_BAD0);
      chk("session_wr_drop", 32'(bus.host_wr_drop), 1);
      tick();
      chk("drop_one_pulse", 32'(bus.host_wr_drop), 0);
      cmp_acc(1'b1, 5'd22, 32'hFFFF_FFFF);
      chk("cmp_oor_wr_err", 32'(bus.addr_err), 1);
      tick();
      chk("addr_err_pulse", 32'(bus.addr_err), 0);
      cmp_acc(1'b0, 5'd22, '0);
      chk("cmp_oor_rd_valid", 32'(bus.cmp_rvalid), 1);
      chk("cmp_oor_rd_zero", bus.cmp_rdata, 0);
      chk("cmp_oor_rd_err", 32'(bus.addr_err), 1);
      bus.cmp_commit = 1'b1;
      tick();
      bus.cmp_commit = 1'b0;
      bus.host_rd_en = 1'b1; bus.host_addr = 5'd0;
      tick();
      chk("rd_during_commit", bus.host_rd_data, 32'h1111_1111);
      tick();
      bus.host_rd_en = 1'b0;
      chk("rd_after_commit", bus.host_rd_data, 32'h1234_5678);
      chk("idle_after_commit", 32'(bus.busy), 0);

      // Session 2: abort with simultaneous commit
      open_session();
      cmp_acc(1'b1, 5'd3, 32'hDEAD_BEEF);
      bus.cmp_abort = 1'b1; bus.cmp_commit = 1'b1;
      tick();
      bus.cmp_abort = 1'b0; bus.cmp_commit = 1'b0;
      chk("abort_wins_idle", 32'(bus.busy), 0);
      host_rd(5'd3);
      chk("abort_discards", bus.host_rd_data, 32'h3333_3333);

      // Session 3: COPY refresh and P write (mirror when enabled)
      open_session();
      cmp_acc(1'b0, 5'd3, '0);
      chk("copy_refresh", bus.cmp_rdata, 32'h3333_3333);
      cmp_acc(1'b1, 5'd10, 32'hA5A5_A5A5);
      bus.cmp_commit = 1'b1;
      tick();
      bus.cmp_commit = 1'b0;
      tick();
      host_rd(5'd10);
      chk("p12_written", bus.host_rd_data, 32'hA5A5_A5A5);
`ifdef EKF_MEM_SYMM_EN
      exp13 = 32'hA5A5_A5A5;
`else
      exp13 = 32'h0000_000D;
`endif
      host_rd(5'd13);
      chk("p21_mirror", bus.host_rd_data, exp13);

      host_wr(5'd22, 32'hCAFE_F00D);
      chk("host_oor_wr_err", 32'(bus.addr_err), 1);
      chk("host_oor_no_drop", 32'(bus.host_wr_drop), 0);
      host_rd(5'd22);
      chk("host_oor_rd_valid", 32'(bus.host_rd_valid), 1);
      chk("host_oor_rd_zero", bus.host_rd_data, 0);
      chk("host_oor_rd_err", 32'(bus.addr_err), 1);
      host_rd(5'd5);
      chk("oor_no_alter5", bus.host_rd_data, 32'h3F80_0000);
      host_rd(5'd21);
      chk("oor_no_alter21", bus.host_rd_data, 0);

      bus.cmp_commit = 1'b1;
      tick();
      bus.cmp_commit = 1'b0;
      chk("commit_in_idle_ignored", 32'(bus.busy), 0);
      host_rd(5'd0);
      chk("act_unchanged", bus.host_rd_data, 32'h1234_5678);

      // Reset mid-session clears both banks
      open_session();
      cmp_acc(1'b1, 5'd0, 32'h7777_7777);
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", 32'(bus.busy), 0);
      tick();
      rst_n = 1'b1;
      host_rd(5'd0);
      chk("midreset_addr0", bus.host_rd_data, 0);
      host_rd(5'd5);
      chk("midreset_addr5", bus.host_rd_data, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ekf_state_mem.md
Name: ekf_state_mem

Overview:
Double-buffered register-file store for the EKF state vector x, covariance P and measurement z. It sits directly downstream of ekf_control_fsm, taking the FSM's mem_wr_en/mem_addr/mem_wr_data and returning mem_rd_data. It also gives the predict/update datapath a second, handshaked port into a private working bank. Datapath results become host-visible atomically on commit, or are discarded on abort.

Parameters:
STATE_DIM, 4, state vector length N
MEAS_DIM, 2, measurement length M
DATA_WIDTH, 32, word width
DEPTH, STATE_DIM*STATE_DIM+STATE_DIM+MEAS_DIM, words per bank (22 at defaults)
ADDR_W, $clog2(DEPTH), address width (5 at defaults)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
host_wr_en  in  1  host write strobe (from control FSM)
host_rd_en  in  1  host read strobe
host_addr  in  ADDR_W  host word address
host_wr_data  in  DATA_WIDTH  host write data
host_rd_data  out  DATA_WIDTH  host read data, active bank
host_rd_valid  out  1  host_rd_data valid
host_wr_drop  out  1  one-cycle pulse: host write rejected
cmp_start  in  1  pulse: open compute session
cmp_commit  in  1  pulse: publish working bank
cmp_abort  in  1  pulse: discard working bank
cmp_req  in  1  compute access request
cmp_we  in  1  1 = write, 0 = read (qualified by cmp_req)
cmp_addr  in  ADDR_W  compute word address
cmp_wdata  in  DATA_WIDTH  compute write data
cmp_gnt  out  1  access accepted this cycle
cmp_rdata  out  DATA_WIDTH  compute read data
cmp_rvalid  out  1  cmp_rdata valid
busy  out  1  session in progress (state != IDLE)
addr_err  out  1  one-cycle pulse: out-of-range access attempted

Behaviour:
- Address map, identical for host and compute ports:
  - x[i] at i.
  - P[r][c] at N + r*N + c.
  - z[k] at N + N*N + k.
  - Addresses >= DEPTH are invalid.
- Storage: two banks of DEPTH words, bank0 and bank1. act_sel names the active bank; the other bank is the working bank.
- Reset (asynchronous): all words of both banks = 0; act_sel = 0; state = IDLE; all outputs = 0.
- States and transitions:
  - IDLE: on cmp_start, go to COPY.
  - COPY: one cycle; working bank <= active bank, all words in parallel; then go to SESSION.
  - SESSION:
    - cmp_abort: go to IDLE, working bank contents ignored.
    - otherwise cmp_commit: go to COMMIT.
    - abort has priority over commit in the same cycle.
  - COMMIT: one cycle; act_sel toggles; then go to IDLE.
- cmp_start outside IDLE is ignored. cmp_commit/cmp_abort outside SESSION are ignored.
- Host port:
  - Reads are always from the active bank.
  - Read latency is 1 cycle: host_rd_valid is high the cycle after host_rd_en.
  - Host writes go to the active bank in IDLE only. In any other state the write is dropped and host_wr_drop pulses the next cycle.
  - A host read in the cycle after a host write to the same address returns the new value.
  - A host read during COMMIT returns the pre-swap bank; the read in the cycle after COMMIT returns the new bank.
- Compute port:
  - cmp_gnt = cmp_req && state == SESSION (combinational). Requests outside SESSION receive no grant and must be held by the requester.
  - A granted write updates the working bank at the clock edge.
  - A granted read returns working-bank data with 1-cycle latency via cmp_rvalid/cmp_rdata.
  - Back-to-back accesses at one per cycle are allowed. A read immediately following a write to the same address returns the written data.
- Out-of-range addresses (either port):
  - Writes are discarded.
  - Reads return 0 with valid still asserted.
  - addr_err pulses the next cycle.
- Data is opaque bits; no arithmetic is performed on stored words.
- Reset asserted mid-session: immediate return to IDLE with both banks cleared; no partial commit.

Optional Feature:
EKF_MEM_SYMM_EN: when defined, a granted compute write to P[r][c] with r != c also writes P[c][r] in the same cycle, keeping P symmetric. The same applies during a commit-pending session. Host writes are not mirrored. When undefined, only the addressed word is written.

Decomposition:
- Package ekf_mem_pkg holds:
  - Base-offset constants X_BASE, P_BASE, Z_BASE as functions of N and M.
  - The state enum {IDLE, COPY, SESSION, COMMIT}.
  - The helper function p_addr(r,c).
- One natural sub-module: ekf_mem_addr_dec. It is combinational: address -> region, in-range flag, and (r,c) decode plus mirrored address for the symmetry feature. It is instantiated once per port.

Test Plan:
- Reset, then host write 0x3F800000 to addr 5, then host read addr 5 -> host_rd_valid next cycle, data 0x3F800000. Read addr 21 -> 0.
- cmp_start; in SESSION, compute write 0x12345678 to addr 0; host read addr 0 -> old value. cmp_commit; host read after COMMIT -> 0x12345678.
- Session: compute write 0xDEADBEEF to addr 3, then cmp_abort; host read addr 3 -> pre-session value. Next session, compute read addr 3 -> pre-session value (COPY refresh).
- Host write during SESSION -> host_wr_drop pulses, active bank unchanged. cmp_req in IDLE -> cmp_gnt stays 0.
- Host or compute access to addr 22 -> addr_err pulse, read returns 0, no bank word altered. cmp_commit and cmp_abort asserted together -> behaves as abort.
- EKF_MEM_SYMM_EN defined: compute write 0xA5A5A5A5 to P[1][2] (addr 10), commit -> addr 10 and addr 13 both read 0xA5A5A5A5. Undefined -> addr 13 unchanged.
